// File: rtl/qrs_adaptive_detector.sv
// Adaptive-threshold QRS peak detector: SEARCH/TRACK/REFRACT FSM with a ring-buffer peak average.
// Optional macro RR_INTERVAL_EN adds the rr_interval output (valid samples between detections).
module qrs_adaptive_detector #(
  parameter int DATA_W      = 16,
  parameter int AVG_LOG2    = 3,
  parameter int REFRACT_SMP = 4,
  parameter int THR_SHIFT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] Tn,
  output logic              qrs_pulse,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] peak_avg,
  output logic [1:0]        state_o
`ifdef RR_INTERVAL_EN
  ,
  output logic [15:0]       rr_interval
`endif
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (REFRACT_SMP > 0) ? $clog2(REFRACT_SMP + 1) : 1;

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, REFRACT = 2'd2} state_t;

  state_t                         r_state;
  logic [DATA_W-1:0]              r_max;
  logic [CNT_W-1:0]               r_cnt;
  logic [AVG_LOG2-1:0]            r_wptr;
  logic [SUM_W-1:0]               r_sum;
  logic [DEPTH-1:0][DATA_W-1:0]   r_ring;

  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_avg_shr;
  logic [DATA_W-1:0] w_thr;
  logic              w_above;
  logic [SUM_W-1:0]  w_sum_next;

  // Most negative input has no positive twin; clamp it to the largest positive magnitude.
  always_comb begin
    w_mag = sample_in;
    if (sample_in[DATA_W-1]) begin
      if (sample_in == {1'b1, {(DATA_W-1){1'b0}}})
        w_mag = {1'b0, {(DATA_W-1){1'b1}}};
      else
        w_mag = -sample_in;
    end
  end

  assign w_avg_shr  = peak_avg >> THR_SHIFT;
  assign w_thr      = (Tn > w_avg_shr) ? Tn : w_avg_shr;
  assign w_above    = (w_mag > w_thr);
  assign w_sum_next = r_sum - {{AVG_LOG2{1'b0}}, r_ring[r_wptr]} + {{AVG_LOG2{1'b0}}, r_max};

  assign peak_avg = r_sum[SUM_W-1:AVG_LOG2];
  assign state_o  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SEARCH;
      r_max      <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_sum      <= '0;
      r_ring     <= '0;
      qrs_pulse  <= 1'b0;
      peak_value <= '0;
    end else begin
      qrs_pulse <= 1'b0;
      if (sample_valid) begin
        case (r_state)
          SEARCH: begin
            if (w_above) begin
              r_state <= TRACK;
              r_max   <= w_mag;
            end
          end
          TRACK: begin
            if (w_above) begin
              if (w_mag > r_max) r_max <= w_mag;
            end else begin
              qrs_pulse      <= 1'b1;
              peak_value     <= r_max;
              r_ring[r_wptr] <= r_max;
              r_sum          <= w_sum_next;
              r_wptr         <= r_wptr + 1'b1;
              if (REFRACT_SMP == 0) begin
                r_state <= SEARCH;
              end else begin
                r_state <= REFRACT;
                r_cnt   <= CNT_W'(REFRACT_SMP);
              end
            end
          end
          REFRACT: begin
            // The sample that brings the count to zero is consumed here, not evaluated.
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= SEARCH;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

`ifdef RR_INTERVAL_EN
  logic [15:0] r_rr_cnt;
  logic        r_seen_first;
  logic [15:0] w_rr_next;
  logic        w_detect;

  assign w_rr_next = (r_rr_cnt == 16'hFFFF) ? 16'hFFFF : r_rr_cnt + 16'd1;
  assign w_detect  = sample_valid && (r_state == TRACK) && !w_above;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_cnt     <= '0;
      r_seen_first <= 1'b0;
      rr_interval  <= '0;
    end else if (sample_valid) begin
      if (w_detect) begin
        if (r_seen_first) rr_interval <= w_rr_next;
        r_seen_first <= 1'b1;
        r_rr_cnt     <= '0;
      end else begin
        r_rr_cnt <= w_rr_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qrs_adaptive_detector.sv
// Directed-vector bench for qrs_adaptive_detector with Tn=0x0010 and default parameters.
module tb_qrs_adaptive_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] Tn;
  logic        qrs_pulse;
  logic [15:0] peak_value;
  logic [15:0] peak_avg;
  logic [1:0]  state_o;
`ifdef RR_INTERVAL_EN
  logic [15:0] rr_interval;
`endif

  int errors = 0;
  int checks = 0;

  qrs_adaptive_detector #(
    .DATA_W(16), .AVG_LOG2(3), .REFRACT_SMP(4), .THR_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid), .Tn(Tn),
    .qrs_pulse(qrs_pulse), .peak_value(peak_value), .peak_avg(peak_avg), .state_o(state_o)
`ifdef RR_INTERVAL_EN
    , .rr_interval(rr_interval)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic [15:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (qrs_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0h want 0", qrs_pulse); end
    checks++; if (peak_value !== 16'h0) begin errors++; $display("FAIL reset_peak: got %h want 0000", peak_value); end
    checks++; if (peak_avg !== 16'h0) begin errors++; $display("FAIL reset_avg: got %h want 0000", peak_avg); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
`ifdef RR_INTERVAL_EN
    checks++; if (rr_interval !== 16'h0) begin errors++; $display("FAIL reset_rr: got %0d want 0", rr_interval); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(16'h000A, 1'b1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL basic_below: state %0d want 0", state_o); end
    step(16'h002F, 1'b1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_track: state %0d want 1", state_o); end
    step(16'h00A0, 1'b1);
    step(16'h01F0, 1'b1);
    step(16'h0025, 1'b1);
    checks++; if (state_o !== 2'd1 || qrs_pulse !== 1'b0) begin errors++; $display("FAIL basic_hold: state %0d pulse %0h want 1/0", state_o, qrs_pulse); end
    step(16'h0005, 1'b1);
    checks++; if (qrs_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %0h want 1", qrs_pulse); end
    checks++; if (peak_value !== 16'h01F0) begin errors++; $display("FAIL basic_peak: got %h want 01f0", peak_value); end
    checks++; if (peak_avg !== 16'h003E) begin errors++; $display("FAIL basic_avg: got %h want 003e", peak_avg); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL basic_refract: state %0d want 2", state_o); end
  endtask

  task automatic test_refract();
    for (int i = 1; i <= 4; i++) begin
      step(16'h0100, 1'b1);
      checks++;
      if (state_o !== ((i < 4) ? 2'd2 : 2'd0) || qrs_pulse !== 1'b0) begin
        errors++; $display("FAIL refract_%0d: state %0d pulse %0h want %0d/0", i, state_o, qrs_pulse, (i < 4) ? 2 : 0);
      end
    end
    step(16'h0100, 1'b1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL refract_exit: state %0d want 1", state_o); end
    step(16'h0005, 1'b1);
    checks++; if (qrs_pulse !== 1'b1 || peak_value !== 16'h0100) begin errors++; $display("FAIL refract_peak: pulse %0h peak %h want 1/0100", qrs_pulse, peak_value); end
    checks++; if (peak_avg !== 16'h005E) begin errors++; $display("FAIL refract_avg: got %h want 005e", peak_avg); end
    repeat (4) step(16'h0000, 1'b1);
  endtask

  task automatic test_threshold_boundary();
    do_reset();
    step(16'h0010, 1'b1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL thr_equal_pos: state %0d want 0", state_o); end
    step(16'hFFF0, 1'b1);
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL thr_equal_neg: state %0d want 0", state_o); end
    step(16'hFF00, 1'b1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL thr_neg_track: state %0d want 1", state_o); end
    step(16'h0010, 1'b1);
    checks++; if (qrs_pulse !== 1'b1 || peak_value !== 16'h0100) begin errors++; $display("FAIL thr_detect: pulse %0h peak %h want 1/0100", qrs_pulse, peak_value); end
    checks++; if (peak_avg !== 16'h0020) begin errors++; $display("FAIL thr_avg: got %h want 0020", peak_avg); end
    repeat (4) step(16'h0000, 1'b1);
  endtask

  task automatic test_saturate_stall();
    step(16'h8000, 1'b1);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL sat_track: state %0d want 1", state_o); end
    for (int i = 0; i < 10; i++) begin
      step(16'h0000, 1'b0);
      checks++;
      if (state_o !== 2'd1 || qrs_pulse !== 1'b0) begin
        errors++; $display("FAIL stall_%0d: state %0d pulse %0h want 1/0", i, state_o, qrs_pulse);
      end
    end
    step(16'h7FFE, 1'b1);
    step(16'h0000, 1'b1);
    checks++; if (qrs_pulse !== 1'b1 || peak_value !== 16'h7FFF) begin errors++; $display("FAIL sat_peak: pulse %0h peak %h want 1/7fff", qrs_pulse, peak_value); end
    checks++; if (peak_avg !== 16'h101F) begin errors++; $display("FAIL sat_avg: got %h want 101f", peak_avg); end
    repeat (4) step(16'h0000, 1'b1);
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] exp_avg;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step((k % 2 == 1) ? 16'h0080 : 16'hFF80, 1'b1);
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL wrap_track_%0d: state %0d want 1", k, state_o); end
      step(16'h0000, 1'b1);
      exp_avg = (k >= 8) ? 16'h0080 : 16'(k * 16);
      checks++;
      if (qrs_pulse !== 1'b1 || peak_value !== 16'h0080 || peak_avg !== exp_avg) begin
        errors++; $display("FAIL wrap_%0d: pulse %0h peak %h avg %h want 1/0080/%h", k, qrs_pulse, peak_value, peak_avg, exp_avg);
      end
      repeat (4) step(16'h0000, 1'b1);
    end
    step(16'h0080, 1'b1);
    @(negedge clk);
    rst = 1'b1; sample_in = 16'h0000; sample_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (qrs_pulse !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got %0h want 0", qrs_pulse); end
    checks++; if (state_o !== 2'd0 || peak_value !== 16'h0 || peak_avg !== 16'h0) begin
      errors++; $display("FAIL rst_mid_clear: state %0d peak %h avg %h want 0/0000/0000", state_o, peak_value, peak_avg);
    end
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    step(16'h0080, 1'b1);
    step(16'h0000, 1'b1);
    checks++; if (peak_avg !== 16'h0010) begin errors++; $display("FAIL ring_cleared: avg %h want 0010", peak_avg); end
    repeat (4) step(16'h0000, 1'b1);
  endtask

`ifdef RR_INTERVAL_EN
  task automatic test_rr();
    do_reset();
    step(16'h0080, 1'b1);
    step(16'h0000, 1'b1);
    checks++; if (rr_interval !== 16'd0) begin errors++; $display("FAIL rr_first: got %0d want 0", rr_interval); end
    repeat (48) step(16'h0000, 1'b1);
    step(16'h0080, 1'b1);
    step(16'h0000, 1'b1);
    checks++; if (qrs_pulse !== 1'b1 || rr_interval !== 16'd50) begin errors++; $display("FAIL rr_50: pulse %0h rr %0d want 1/50", qrs_pulse, rr_interval); end
  endtask
`endif

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; Tn = 16'h0010;
    test_reset();
    test_basic();
    test_refract();
    test_threshold_boundary();
    test_saturate_stall();
    test_wrap_and_reset();
`ifdef RR_INTERVAL_EN
    test_rr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qrs_adaptive_detector.md
QRS_ADAPTIVE_DETECTOR -- requirements
Module: qrs_adaptive_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, signed two's complement.
REQ-002 SHALL have parameter AVG_LOG2, default 3: log2 of the peak-history depth (8 peaks).
REQ-003 SHALL have parameter REFRACT_SMP, default 4: refractory length in valid samples.
REQ-004 SHALL have parameter THR_SHIFT, default 1: right shift applied to peak_avg to form the adaptive threshold.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sample_in, input, DATA_W bits: signed wavelet detail coefficient.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is qualified this cycle.
REQ-009 SHALL have port Tn, input, DATA_W bits: unsigned noise-floor threshold.
REQ-010 SHALL have port qrs_pulse, output, 1 bit: single-cycle QRS detection strobe.
REQ-011 SHALL have port peak_value, output, DATA_W bits: magnitude of the last detected peak.
REQ-012 SHALL have port peak_avg, output, DATA_W bits: mean of the last 2^AVG_LOG2 peaks.
REQ-013 SHALL have port state_o, output, 2 bits: current FSM state encoding.

Function
REQ-014 SHALL form mag = |sample_in|, saturating the most negative value to 2^(DATA_W-1)-1.
REQ-015 SHALL compute thr = max(Tn, peak_avg >> THR_SHIFT), combinationally, each cycle.
REQ-016 SHALL implement FSM states SEARCH=0, TRACK=1, REFRACT=2; encoding 3 unused and SHALL return to SEARCH.
REQ-017 SHALL advance state, counters and the tracked maximum only on cycles with sample_valid=1; with sample_valid=0 everything holds and qrs_pulse=0.
REQ-018 SEARCH: mag > thr (strict) -> TRACK, with tracked max loaded from mag; mag = thr stays in SEARCH.
REQ-019 TRACK: mag > thr -> max = max(max, mag); mag <= thr -> detection.
REQ-020 On detection, at the same clock edge, SHALL register qrs_pulse=1 for exactly one cycle and peak_value=max.
REQ-021 On detection, at the same clock edge, SHALL write max into the ring buffer at the write pointer, subtract the overwritten entry from the running sum and add max.
REQ-022 On detection, at the same clock edge, SHALL advance the write pointer modulo 2^AVG_LOG2.
REQ-023 Detection SHALL leave TRACK for REFRACT with counter=REFRACT_SMP, or go directly to SEARCH when REFRACT_SMP=0.
REQ-024 REFRACT: SHALL ignore samples and decrement the counter per valid sample; the valid sample that reaches 0 SHALL move the FSM to SEARCH, and the next valid sample SHALL be evaluated.
REQ-025 Running sum SHALL be DATA_W+AVG_LOG2 bits wide with no overflow; peak_avg = sum >> AVG_LOG2, updated in the same cycle qrs_pulse is high.
REQ-026 Ring buffer entries SHALL start at zero, so peak_avg averages zeros until the buffer has filled once.
REQ-027 Write pointer wrap SHALL be seamless: the 2^AVG_LOG2+1th peak overwrites the oldest entry.

Reset
REQ-028 rst=1 SHALL, at the next edge: force SEARCH; clear qrs_pulse, peak_value, peak_avg, sum, write pointer, refractory counter, tracked max and every ring entry.
REQ-029 rst asserted mid-TRACK or mid-REFRACT SHALL abandon the peak with no qrs_pulse; rst SHALL have priority over sample_valid.

Configuration
REQ-030 Macro RR_INTERVAL_EN defined SHALL add output rr_interval, 16 bits: count of valid samples between consecutive detections, latched on qrs_pulse.
REQ-031 The RR counter SHALL saturate at 0xFFFF and reset to 0 on rst; rr_interval SHALL read 0 until the second detection.
REQ-032 Macro RR_INTERVAL_EN undefined SHALL omit the port and its counter entirely; all other behaviour is identical.

Verification (DATA_W=16, AVG_LOG2=3, REFRACT_SMP=4, THR_SHIFT=1, Tn=0x0010)
REQ-033 Reset held 2 cycles -> qrs_pulse=0, peak_value=0, peak_avg=0, state_o=0.
REQ-034 Valid samples 0x000A,0x002F,0x00A0,0x01F0,0x0025,0x0005 -> TRACK entered on 0x002F; qrs_pulse after 0x0005; peak_value=0x01F0; peak_avg=0x003E.
REQ-035 Then 4 valid samples of 0x0100 -> no TRACK (REFRACT); 5th 0x0100 -> TRACK, since thr=max(0x10,0x1F)=0x1F.
REQ-036 sample_in=0x8000 in SEARCH -> mag=0x7FFF, TRACK entered; sample_valid low for 10 cycles mid-TRACK -> state and max unchanged, no pulse.
REQ-037 Nine isolated peaks of 0x0080 -> peak_avg=0x0080 after the 8th and still after the 9th (wrap); rst asserted mid-TRACK -> no pulse, all cleared.
REQ-038 With RR_INTERVAL_EN: detections 50 valid samples apart -> rr_interval=50.
